// File: rtl/axi3_rd_responder.sv
// axi3_rd_responder
//   AXI3 read-channel slave that serves burst reads from an internal
//   word-addressed RAM (mem), preloadable hierarchically. One outstanding
//   transaction at a time, READ_LATENCY idle cycles before the first beat,
//   FIXED / INCR / WRAP bursts. Illegal WRAP lengths or any size other
//   than 4 bytes return SLVERR beats with zero data.
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   arid..arvalid      AR channel inputs (id, byte address, len, size, burst)
//   arready            AR accepted (registered, high only while idle)
//   rid, rdata, rresp  R channel payload (held stable while rready is low)
//   rlast, rvalid      final-beat flag and data valid
//   rready             initiator ready
module axi3_rd_responder #(
  parameter int BUS_WIDTH    = 4,
  parameter int ADDR_WIDTH   = 16,
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [BUS_WIDTH-1:0]  arid,
  input  logic [31:0]           araddr,
  input  logic [3:0]            arlen,
  input  logic [2:0]            arsize,
  input  logic [1:0]            arburst,
  input  logic                  arvalid,
  output logic                  arready,
  output logic [BUS_WIDTH-1:0]  rid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [1:0]            rresp,
  output logic                  rlast,
  output logic                  rvalid,
  input  logic                  rready
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_FETCH, S_BURST} state_t;

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  state_t                state, state_nxt;
  logic [3:0]            wait_cnt;
  logic [3:0]            beat_cnt;
  logic [31:0]           addr;
  logic [3:0]            len_q;
  logic [1:0]            burst_q;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] ram_p1;
  logic                  ar_hs, r_hs;
  logic                  load_beat, ram_en;

  function automatic logic [31:0] next_addr(input logic [31:0] a,
                                            input logic [1:0]  burst,
                                            input logic [3:0]  len);
    logic [31:0] mask;
    logic [31:0] inc;
    mask = {26'd0, len, 2'b11};
    inc  = a + 32'd4;
    case (burst)
      2'b00:   next_addr = a;
      2'b10:   next_addr = (a & ~mask) | (inc & mask);
      default: next_addr = inc;
    endcase
  endfunction

  assign ar_hs = arvalid && arready;
  assign r_hs  = rvalid && rready;

  // In BURST the output register loads either the first word (rvalid still
  // low) or the prefetched next word on a non-final handshake.
  assign load_beat = (state == S_BURST) && (!rvalid || (r_hs && !rlast));
  // The RAM read runs one word ahead of the output register, so every load
  // also fetches the following word and beats stream without bubbles.
  assign ram_en    = (state == S_FETCH) || load_beat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (ar_hs) state_nxt = (READ_LATENCY > 0) ? S_WAIT : S_FETCH;
      S_WAIT:  if (wait_cnt == 4'd0) state_nxt = S_FETCH;
      S_FETCH: state_nxt = S_BURST;
      S_BURST: if (r_hs && rlast) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Control and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      arready  <= 1'b0;
      wait_cnt <= 4'd0;
      beat_cnt <= 4'd0;
      rvalid   <= 1'b0;
      rlast    <= 1'b0;
      rid      <= '0;
      rresp    <= 2'b00;
      rdata    <= '0;
    end else begin
      arready <= (state_nxt == S_IDLE);
      if (ar_hs) begin
        wait_cnt <= 4'(READ_LATENCY - 1);
        beat_cnt <= arlen;
        rid      <= arid;
      end
      if (state == S_WAIT && wait_cnt != 4'd0)
        wait_cnt <= wait_cnt - 4'd1;
      if (load_beat) begin
        rvalid <= 1'b1;
        rdata  <= err_q ? '0 : ram_p1;
        rresp  <= err_q ? 2'b10 : 2'b00;
        if (rvalid) begin
          beat_cnt <= beat_cnt - 4'd1;
          rlast    <= (beat_cnt == 4'd1);
        end else begin
          rlast    <= (beat_cnt == 4'd0);
        end
      end else if (r_hs && rlast) begin
        rvalid <= 1'b0;
        rlast  <= 1'b0;
      end
    end
  end

  // Stage p0 -> p1: request capture and RAM read
  always_ff @(posedge clk) begin
    if (ar_hs) begin
      addr    <= araddr;
      len_q   <= arlen;
      burst_q <= arburst;
      err_q   <= (arsize != 3'd2) ||
                 (arburst == 2'b10 && !(arlen inside {4'd1, 4'd3, 4'd7, 4'd15}));
    end else if (ram_en) begin
      addr <= next_addr(addr, burst_q, len_q);
    end
    if (ram_en)
      ram_p1 <= mem[addr[ADDR_WIDTH+1:2]];
  end

endmodule

// File: tb/tb_axi3_rd_responder.sv
module tb_axi3_rd_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [3:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  int checks = 0;
  int errors = 0;

  axi3_rd_responder #(
    .BUS_WIDTH(4), .ADDR_WIDTH(16), .DATA_WIDTH(32), .READ_LATENCY(2)
  ) dut (
    .clk(clk), .rst(rst),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pre(input int i);
    return 32'(i) * 32'h01010101;
  endfunction

  // Drive one AR handshake (caller is at a sample point with arready high),
  // then count edges until rvalid, bounded.
  task automatic send_ar(input logic [3:0] id, input logic [31:0] a,
                         input logic [3:0] len, input logic [2:0] size,
                         input logic [1:0] burst, output int lat);
    arid = id; araddr = a; arlen = len; arsize = size; arburst = burst;
    arvalid = 1'b1;
    @(posedge clk); #1;
    arvalid = 1'b0;
    lat = 0;
    while (!rvalid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if ({arready, rvalid, rlast, rid, rdata, rresp} !== '0) begin
        errors++;
        $display("FAIL reset_outputs cycle %0d: got arready=%b rvalid=%b rlast=%b rid=%h rdata=%h rresp=%b, want all 0",
                 c, arready, rvalid, rlast, rid, rdata, rresp);
      end
      @(posedge clk); #1;
    end
    rst = 1'b0;
    checks++;
    if (arready !== 1'b0) begin
      errors++; $display("FAIL reset_arready_before_edge got %b want 0", arready);
    end
    @(posedge clk); #1;
    checks++;
    if (arready !== 1'b1 || rvalid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release got arready=%b rvalid=%b want 1 0", arready, rvalid);
    end
  endtask

  task automatic test_incr;
    int lat;
    rready = 1'b1;
    send_ar(4'd2, 32'h40, 4'd7, 3'd2, 2'b01, lat);
    checks++;
    if (lat != 4) begin errors++; $display("FAIL incr_latency got %0d want 4", lat); end
    for (int b = 0; b < 8; b++) begin
      checks++;
      if (rvalid !== 1'b1 || rdata !== pre(16 + b) || rid !== 4'd2 ||
          rlast !== (b == 7) || rresp !== 2'b00) begin
        errors++;
        $display("FAIL incr_beat%0d got v=%b d=%h id=%h last=%b resp=%b want v=1 d=%h id=2 last=%b resp=0",
                 b, rvalid, rdata, rid, rlast, rresp, pre(16 + b), (b == 7));
      end
      @(posedge clk); #1;
    end
    checks++;
    if (rvalid !== 1'b0 || arready !== 1'b1) begin
      errors++; $display("FAIL incr_end got rvalid=%b arready=%b want 0 1", rvalid, arready);
    end
  endtask

  task automatic test_wrap;
    int lat;
    rready = 1'b1;
    send_ar(4'd5, 32'h18, 4'd7, 3'd2, 2'b10, lat);
    checks++;
    if (lat != 4) begin errors++; $display("FAIL wrap_latency got %0d want 4", lat); end
    for (int b = 0; b < 8; b++) begin
      checks++;
      if (rvalid !== 1'b1 || rdata !== pre((6 + b) % 8) || rlast !== (b == 7) ||
          rresp !== 2'b00 || rid !== 4'd5) begin
        errors++;
        $display("FAIL wrap_beat%0d got v=%b d=%h last=%b resp=%b id=%h want d=%h last=%b",
                 b, rvalid, rdata, rlast, rresp, rid, pre((6 + b) % 8), (b == 7));
      end
      @(posedge clk); #1;
    end
    checks++;
    if (rvalid !== 1'b0) begin errors++; $display("FAIL wrap_end rvalid got %b want 0", rvalid); end
  endtask

  task automatic test_backpressure;
    int lat;
    int hs;
    int c;
    logic [3:0]  pat;
    logic [31:0] prev_d;
    logic        prev_l;
    logic        prev_r;
    pat = 4'b1001;
    rready = 1'b0;
    send_ar(4'd3, 32'h80, 4'd3, 3'd2, 2'b01, lat);
    checks++;
    if (lat != 4) begin errors++; $display("FAIL bp_latency got %0d want 4", lat); end
    hs = 0; c = 0; prev_r = 1'b1; prev_d = '0; prev_l = 1'b0;
    while (hs < 4 && c < 40) begin
      checks++;
      if (rvalid !== 1'b1) begin
        errors++; $display("FAIL bp_rvalid cycle %0d got %b want 1", c, rvalid);
      end
      if (!prev_r) begin
        checks++;
        if (rdata !== prev_d || rlast !== prev_l) begin
          errors++;
          $display("FAIL bp_hold cycle %0d got d=%h last=%b want d=%h last=%b",
                   c, rdata, rlast, prev_d, prev_l);
        end
      end
      rready = pat[3 - (c % 4)];
      if (rready) begin
        checks++;
        if (rdata !== pre(32 + hs) || rlast !== (hs == 3)) begin
          errors++;
          $display("FAIL bp_beat%0d got d=%h last=%b want d=%h last=%b",
                   hs, rdata, rlast, pre(32 + hs), (hs == 3));
        end
        hs++;
      end
      prev_r = rready; prev_d = rdata; prev_l = rlast;
      @(posedge clk); #1;
      c++;
    end
    checks++;
    if (hs != 4 || c != 8 || rvalid !== 1'b0 || arready !== 1'b1) begin
      errors++;
      $display("FAIL bp_end got hs=%0d cycles=%0d rvalid=%b arready=%b want 4 8 0 1",
               hs, c, rvalid, arready);
    end
    rready = 1'b1;
  endtask

  task automatic test_error;
    int lat;
    rready = 1'b1;
    send_ar(4'd7, 32'h0, 4'd3, 3'd1, 2'b01, lat);
    checks++;
    if (lat != 4) begin errors++; $display("FAIL err_latency got %0d want 4", lat); end
    arid = 4'd9; araddr = 32'h8; arlen = 4'd0; arsize = 3'd2; arburst = 2'b01;
    arvalid = 1'b1;
    for (int b = 0; b < 4; b++) begin
      checks++;
      if (rvalid !== 1'b1 || rresp !== 2'b10 || rdata !== 32'h0 ||
          rlast !== (b == 3) || arready !== 1'b0) begin
        errors++;
        $display("FAIL err_beat%0d got v=%b resp=%b d=%h last=%b arready=%b want v=1 resp=10 d=0 last=%b arready=0",
                 b, rvalid, rresp, rdata, rlast, arready, (b == 3));
      end
      @(posedge clk); #1;
    end
    checks++;
    if (rvalid !== 1'b0 || arready !== 1'b1) begin
      errors++; $display("FAIL err_end got rvalid=%b arready=%b want 0 1", rvalid, arready);
    end
    @(posedge clk); #1;
    arvalid = 1'b0;
    lat = 0;
    while (!rvalid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (lat != 4 || rdata !== pre(2) || rid !== 4'd9 || rresp !== 2'b00 || rlast !== 1'b1) begin
      errors++;
      $display("FAIL err_second_ar got lat=%0d d=%h id=%h resp=%b last=%b want 4 %h 9 00 1",
               lat, rdata, rid, rresp, rlast, pre(2));
    end
    @(posedge clk); #1;
  endtask

  task automatic test_fixed_alias;
    int lat;
    rready = 1'b1;
    send_ar(4'd1, 32'hC, 4'd2, 3'd2, 2'b00, lat);
    for (int b = 0; b < 3; b++) begin
      checks++;
      if (rvalid !== 1'b1 || rdata !== pre(3) || rlast !== (b == 2)) begin
        errors++;
        $display("FAIL fixed_beat%0d got v=%b d=%h last=%b want v=1 d=%h last=%b",
                 b, rvalid, rdata, rlast, pre(3), (b == 2));
      end
      @(posedge clk); #1;
    end
    send_ar(4'd4, 32'hFFFF_FFFC, 4'd1, 3'd2, 2'b01, lat);
    checks++;
    if (rdata !== 32'hDEADBEEF || rlast !== 1'b0) begin
      errors++; $display("FAIL alias_beat0 got d=%h last=%b want deadbeef 0", rdata, rlast);
    end
    @(posedge clk); #1;
    checks++;
    if (rdata !== pre(0) || rlast !== 1'b1 || rvalid !== 1'b1) begin
      errors++; $display("FAIL alias_beat1 got d=%h last=%b v=%b want %h 1 1", rdata, rlast, rvalid, pre(0));
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    int lat;
    rready = 1'b1;
    send_ar(4'd6, 32'h100, 4'd7, 3'd2, 2'b01, lat);
    for (int b = 0; b < 2; b++) begin
      checks++;
      if (rdata !== pre(64 + b)) begin
        errors++; $display("FAIL mid_beat%0d got d=%h want %h", b, rdata, pre(64 + b));
      end
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1;
    checks++;
    if (rvalid !== 1'b0 || rlast !== 1'b0 || arready !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset got rvalid=%b rlast=%b arready=%b want 0 0 0", rvalid, rlast, arready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (arready !== 1'b1 || rvalid !== 1'b0) begin
      errors++; $display("FAIL mid_release got arready=%b rvalid=%b want 1 0", arready, rvalid);
    end
    send_ar(4'd8, 32'h0, 4'd0, 3'd2, 2'b01, lat);
    checks++;
    if (lat != 4 || rvalid !== 1'b1 || rdata !== pre(0) || rlast !== 1'b1 ||
        rid !== 4'd8 || rresp !== 2'b00) begin
      errors++;
      $display("FAIL mid_single got lat=%0d v=%b d=%h last=%b id=%h resp=%b want 4 1 %h 1 8 00",
               lat, rvalid, rdata, rlast, rid, rresp, pre(0));
    end
    @(posedge clk); #1;
    checks++;
    if (rvalid !== 1'b0 || arready !== 1'b1) begin
      errors++; $display("FAIL mid_single_end got rvalid=%b arready=%b want 0 1", rvalid, arready);
    end
  endtask

  initial begin
    arid = '0; araddr = '0; arlen = '0; arsize = 3'd2; arburst = 2'b01;
    arvalid = 1'b0; rready = 1'b1;
    for (int i = 0; i < 128; i++) dut.mem[i] = pre(i);
    dut.mem[65535] = 32'hDEADBEEF;
    test_reset;
    test_incr;
    test_wrap;
    test_backpressure;
    test_error;
    test_fixed_alias;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
